// File: rtl/mod_updown_counter_if.sv
// mod_updown_counter_if
//   Control/status bundle for mod_updown_counter.
//   master : driver of the controls (cntEN, init0, load, loadVal, modulus,
//            dir, sat, prescale), observer of the counter outputs.
//   slave  : the counter itself (drives cntOUT, tcOUT, carryOUT, borrowOUT).
//   clk and rst are not part of the bundle; they stay plain ports.
interface mod_updown_counter_if #(
  parameter int unsigned W     = 10,
  parameter int unsigned PRE_W = 8
);
  logic             cntEN;
  logic             init0;
  logic             load;
  logic [W-1:0]     loadVal;
  logic [W-1:0]     modulus;
  logic             dir;
  logic             sat;
  logic [PRE_W-1:0] prescale;
  logic [W-1:0]     cntOUT;
  logic             tcOUT;
  logic             carryOUT;
  logic             borrowOUT;

  modport master (
    output cntEN, init0, load, loadVal, modulus, dir, sat, prescale,
    input  cntOUT, tcOUT, carryOUT, borrowOUT
  );

  modport slave (
    input  cntEN, init0, load, loadVal, modulus, dir, sat, prescale,
    output cntOUT, tcOUT, carryOUT, borrowOUT
  );
endinterface

// File: rtl/mod_updown_counter.sv
// mod_updown_counter
//   Programmable-modulus up/down counter with parallel load, wrap or
//   saturate at the terminal value, and an optional prescaler.
//   Build option: define MODCNT_PRESCALE_EN to include the PRE_W-bit
//   prescaler; otherwise every enabled cycle is a tick and bus.prescale
//   is ignored.
// Ports
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset, highest priority
//   bus  : mod_updown_counter_if.slave
//          in : cntEN, init0, load, loadVal, modulus, dir, sat, prescale
//          out: cntOUT (registered), tcOUT (combinational),
//               carryOUT / borrowOUT (registered one-cycle wrap pulses)
module mod_updown_counter #(
  parameter int unsigned W     = 10,
  parameter int unsigned PRE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mod_updown_counter_if.slave   bus
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         carry_q, carry_d;
  logic         borrow_q, borrow_d;
  logic         tick;

`ifdef MODCNT_PRESCALE_EN
  logic [PRE_W-1:0] pre_q;
  logic             pre_tc;

  // >= rather than == so a prescale value lowered below the running phase
  // ticks immediately instead of rolling through the whole register range.
  assign pre_tc = (pre_q >= bus.prescale);
  assign tick   = bus.cntEN & pre_tc;

  always_ff @(posedge clk) begin
    if (rst || bus.init0 || bus.load) begin
      pre_q <= '0;
    end else if (bus.cntEN) begin
      pre_q <= pre_tc ? '0 : pre_q + PRE_W'(1);
    end
  end
`else
  logic unused_prescale;
  assign unused_prescale = ^bus.prescale;
  assign tick            = bus.cntEN;
`endif

  // Next count for a tick. Up-counting treats anything at or above the
  // modulus as terminal, so a modulus shrunk below the count wraps/clamps
  // on the next tick; down-counting from above the modulus just decrements.
  always_comb begin
    cnt_d    = cnt_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (!bus.dir) begin
      if (cnt_q >= bus.modulus) begin
        if (bus.sat) begin
          cnt_d = bus.modulus;
        end else begin
          cnt_d   = '0;
          carry_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end else begin
      if (cnt_q == '0) begin
        if (bus.sat) begin
          cnt_d = '0;
        end else begin
          cnt_d    = bus.modulus;
          borrow_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.init0) begin
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else if (bus.load) begin
      cnt_q    <= (bus.loadVal > bus.modulus) ? bus.modulus : bus.loadVal;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else if (tick) begin
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end else begin
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end
  end

  assign bus.cntOUT    = cnt_q;
  assign bus.carryOUT  = carry_q;
  assign bus.borrowOUT = borrow_q;
  assign bus.tcOUT     = bus.dir ? (cnt_q == '0) : (cnt_q >= bus.modulus);

endmodule

// File: doc/mod_updown_counter.md
# mod_updown_counter

Parametrised programmable-modulus counter for the digital modulation datapath: the next generation of the fixed-N up-counter. It adds a runtime modulus, up/down direction, parallel load, wrap or saturate mode, and an optional prescaler. It drives symbol/sample timing, PWM period generation and carrier-phase stepping. It provides registered carry/borrow pulses and a combinational terminal-count flag.

## Interface
Parameters:
- W, 10, counter width; modulus and load value are W bits.
- PRE_W, 8, prescaler width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset: synchronous, active-high; highest priority.
- cntEN  in  1  count enable; also gates the prescaler.
- init0  in  1  synchronous clear of counter and prescaler.
- load  in  1  parallel load strobe.
- loadVal  in  W  value for load.
- modulus  in  W  terminal value; count range is 0..modulus inclusive.
- dir  in  1  0 = up, 1 = down.
- sat  in  1  0 = wrap at terminal, 1 = hold at terminal.
- prescale  in  PRE_W  tick every prescale+1 enabled cycles; ignored when the prescaler is compiled out.
- cntOUT  out  W  current count, registered.
- tcOUT  out  1  combinational terminal flag: (dir=0 and cntOUT >= modulus) or (dir=1 and cntOUT = 0).
- carryOUT  out  1  registered one-cycle pulse after an up-wrap.
- borrowOUT  out  1  registered one-cycle pulse after a down-wrap.

## Operation
- Internal tick = cntEN and (prescaler at terminal). Without the prescaler, tick = cntEN.
- Priority per edge: rst > init0 > load > tick > hold.
- rst: cnt=0, prescaler=0, carryOUT=0, borrowOUT=0.
- init0: cnt=0, prescaler=0, pulses=0.
- load: cnt = min(loadVal, modulus); prescaler=0; pulses=0.
- tick, up, cnt < modulus: cnt+1.
- tick, up, cnt >= modulus:
  - wrap: cnt=0, carryOUT=1 next cycle.
  - sat: cnt=modulus, no pulse.
- tick, down, cnt > 0: cnt-1.
- tick, down, cnt = 0:
  - wrap: cnt=modulus, borrowOUT=1 next cycle.
  - sat: hold 0, no pulse.
- Arithmetic is W-bit unsigned; no overflow is possible because cnt never exceeds max(modulus, previous cnt).
- Runtime modulus change below the current cnt:
  - up: treated as terminal on the next tick (wrap to 0 or clamp to the new modulus).
  - down: counts down normally.
- modulus = 0:
  - up/wrap: cnt stays 0, carry pulses every tick.
  - down/wrap: borrow pulses every tick.
- dir and sat are sampled every tick; changing them mid-count takes effect on the next tick, with no restart.
- carryOUT and borrowOUT are never both 1. Each is 0 in any cycle not immediately following a wrapping tick.

## Timing
- Counter latency: cntOUT reflects a tick/load/init0 one cycle after the qualifying edge.
- Pulse timing:
  - Wrap pulses assert on the same edge that wraps cntOUT.
  - Visible high for exactly one cycle, coincident with the wrapped cntOUT value.
- tcOUT is combinational from cntOUT, dir and modulus; it has no register delay.
- Prescaler:
  - Counts 0..prescale on enabled cycles; tick on the enabled cycle where it equals prescale, then restarts at 0.
  - cntEN low freezes the prescaler.
  - prescale=0 gives a tick every enabled cycle.
- Reset mid-count: the next cycle shows all outputs at reset values regardless of other inputs.

## Configuration
- MODCNT_PRESCALE_EN defined: the PRE_W-bit prescaler is instantiated and behaves as above.
- MODCNT_PRESCALE_EN undefined:
  - No prescaler register; tick = cntEN.
  - The prescale port remains and is ignored.
  - All other behaviour is identical.

## Test plan
- Reset and wrap carry (up, wrap, W=4, modulus=5, prescale=0): rst 1 cycle, then cntEN=1 for 8 cycles -> cntOUT 1,2,3,4,5,0,1,2; carryOUT high only with the first 0; tcOUT high while cntOUT=5.
- Down borrow and load clamp (down, wrap, modulus=9): load loadVal=12 -> cntOUT=9; then 10 ticks -> 8..0, then 9 with borrowOUT high one cycle.
- Saturation (sat=1, up, modulus=3): 6 ticks -> 1,2,3,3,3,3; carryOUT never high. Then switch dir=1 -> 2,1,0,0 with no borrow.
- Priority (mid-count at 4): assert init0, load(7) and cntEN together -> cntOUT=0. rst with load -> 0 and pulses cleared.
- Prescaler, with macro (prescale=2, cntEN=1): cntOUT increments every 3rd cycle. Drop cntEN for 5 cycles mid-period -> phase preserved. Without macro: increments every cycle.
- Runtime modulus shrink (up, wrap, cnt=8): set modulus=4 -> next tick cntOUT=0 with carryOUT=1.
